// File: rtl/redirect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : redirect_arbiter
// Purpose  : Prioritised, registered fetch-redirect arbiter with EPC/handler
//            state, a one-entry stall slot and flush strobes. Optional
//            counters are enabled by defining REDIRECT_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module redirect_arbiter #(
  parameter logic [31:0] EXC_HANDLER_PC = 32'h2000,
  parameter logic [31:0] RESET_PC       = 32'h1000
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        stall_core_i,
  input  logic        exc_occured_i,
  input  logic [31:0] exc_pc_i,
  input  logic        iret_i,
  input  logic        jal_i,
  input  logic [31:0] jal_pc_i,
  input  logic        bp_error_i,
  input  logic        alu_branch_i,
  input  logic        alu_jumps_i,
  input  logic [31:0] alu_pc_jmp_i,
  input  logic [31:0] alu_pc_no_jmp_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic [31:0] exc_return_pc_o,
  output logic        in_exc_o
`ifdef REDIRECT_PERF_CNT_EN
  ,
  output logic [31:0] mispredict_cnt_o,
  output logic [31:0] exc_cnt_o
`endif
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_EXC = 1'b1;

  logic [0:0]  r_state;
  logic        r_boot;
  logic        r_pend_v;
  logic [31:0] r_pend_pc;
  logic        r_pend_fid;
  logic        r_pend_iret;
  logic        r_redirect;
  logic [31:0] r_pc;
  logic        r_fif;
  logic        r_fid;
  logic [31:0] r_epc;

  logic        w_iret_req;
  logic        w_soft_req;
  logic [31:0] w_soft_pc;
  logic [31:0] w_bp_pc;
  logic        w_issue;
  logic [31:0] w_pc;
  logic        w_fid;
  logic        w_is_exc;
  logic        w_is_bp;
  logic        w_is_iret;
  logic        w_pend_v_nxt;
  logic [31:0] w_pend_pc_nxt;
  logic        w_pend_fid_nxt;
  logic        w_pend_iret_nxt;

  // iret outside the handler is not a request at all, so a concurrent jal
  // still proceeds. The boot redirect takes precedence over any request.
  always_comb begin
    w_iret_req      = iret_i & (r_state == ST_EXC);
    w_soft_req      = w_iret_req | jal_i;
    w_soft_pc       = w_iret_req ? (r_epc + 32'd4) : jal_pc_i;
    w_bp_pc         = (alu_branch_i & alu_jumps_i) ? alu_pc_jmp_i : alu_pc_no_jmp_i;
    w_issue         = 1'b0;
    w_pc            = r_pc;
    w_fid           = 1'b0;
    w_is_exc        = 1'b0;
    w_is_bp         = 1'b0;
    w_is_iret       = 1'b0;
    w_pend_v_nxt    = r_pend_v;
    w_pend_pc_nxt   = r_pend_pc;
    w_pend_fid_nxt  = r_pend_fid;
    w_pend_iret_nxt = r_pend_iret;
    if (r_boot) begin
      w_issue      = 1'b1;
      w_pc         = RESET_PC;
      w_fid        = 1'b1;
      w_pend_v_nxt = 1'b0;
    end else if (exc_occured_i) begin
      w_issue      = 1'b1;
      w_pc         = EXC_HANDLER_PC;
      w_fid        = 1'b1;
      w_is_exc     = 1'b1;
      w_pend_v_nxt = 1'b0;
    end else if (bp_error_i) begin
      w_issue      = 1'b1;
      w_pc         = w_bp_pc;
      w_fid        = 1'b1;
      w_is_bp      = 1'b1;
      w_pend_v_nxt = 1'b0;
    end else if (w_soft_req) begin
      if (stall_core_i) begin
        w_pend_v_nxt    = 1'b1;
        w_pend_pc_nxt   = w_soft_pc;
        w_pend_fid_nxt  = w_iret_req;
        w_pend_iret_nxt = w_iret_req;
      end else begin
        w_issue      = 1'b1;
        w_pc         = w_soft_pc;
        w_fid        = w_iret_req;
        w_is_iret    = w_iret_req;
        w_pend_v_nxt = 1'b0;
      end
    end else if (r_pend_v && !stall_core_i) begin
      w_issue      = 1'b1;
      w_pc         = r_pend_pc;
      w_fid        = r_pend_fid;
      w_is_iret    = r_pend_iret;
      w_pend_v_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_state     <= ST_RUN;
      r_boot      <= 1'b1;
      r_pend_v    <= 1'b0;
      r_pend_pc   <= 32'd0;
      r_pend_fid  <= 1'b0;
      r_pend_iret <= 1'b0;
      r_redirect  <= 1'b0;
      r_pc        <= RESET_PC;
      r_fif       <= 1'b0;
      r_fid       <= 1'b0;
      r_epc       <= 32'd0;
    end else begin
      r_boot      <= 1'b0;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_pend_fid  <= w_pend_fid_nxt;
      r_pend_iret <= w_pend_iret_nxt;
      r_redirect  <= w_issue;
      r_pc        <= w_pc;
      r_fif       <= w_issue;
      r_fid       <= w_fid;
      // A nested exception keeps the EPC of the original fault.
      if (w_is_exc) begin
        if (r_state == ST_RUN) r_epc <= exc_pc_i;
        r_state <= ST_EXC;
      end else if (w_is_iret) begin
        r_state <= ST_RUN;
      end
    end
  end

`ifdef REDIRECT_PERF_CNT_EN
  logic [31:0] r_mis_cnt;
  logic [31:0] r_exc_cnt;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_mis_cnt <= 32'd0;
      r_exc_cnt <= 32'd0;
    end else begin
      if (w_is_bp)  r_mis_cnt <= r_mis_cnt + 32'd1;
      if (w_is_exc) r_exc_cnt <= r_exc_cnt + 32'd1;
    end
  end

  assign mispredict_cnt_o = r_mis_cnt;
  assign exc_cnt_o        = r_exc_cnt;
`endif

  assign redirect_o      = r_redirect;
  assign redirect_pc_o   = r_pc;
  assign flush_if_o      = r_fif;
  assign flush_id_o      = r_fid;
  assign exc_return_pc_o = r_epc;
  assign in_exc_o        = (r_state == ST_EXC);

endmodule
`default_nettype wire
